gf8_poly_reduce: RTL and testbench

Sequential modular-reduction stage that takes the 15-bit carry-less product from the 8×8 GF(2) polynomial multiplier and reduces it to an 8-bit GF(2^8) element modulo a fixed irreducible polynomial. It sits directly downstream of the multiplier netlist, which produces `y[14:0]`. It is iterative, retiring one high-order product bit per cycle. Valid/ready handshakes on both sides let it sit between a registered multiplier wrapper and any consumer.

---
 rtl/gf8_poly_reduce.sv | 83 ++++++++
 tb/tb_gf8_poly_reduce.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf8_poly_reduce.sv
// Iterative GF(2^8) reduction of a 15-bit carry-less product modulo POLY.
// Retires one high-order product bit per cycle (x^14 down to x^8), then hands the result off.
module gf8_poly_reduce #(
    parameter logic [8:0] POLY = 9'h11B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_res,
    output logic        busy
);

    // A modulus without an x^8 term cannot clear the top bit, so the reduction would be wrong.
    if (POLY[8] != 1'b1) begin : g_bad_poly
        $fatal(1, "gf8_poly_reduce: POLY bit 8 must be 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RED,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [14:0] acc;
    logic [3:0]  cnt;
    logic [14:0] poly_shift;
    logic        accept;
    logic        last_step;

    assign accept     = (state == IDLE) && in_valid;
    assign last_step  = (cnt == 4'd8);
    assign poly_shift = 15'(POLY) << (cnt - 4'd8);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RED;
            RED:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data-independent step count: XOR is applied only when the current top bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= in_prod;
            cnt <= 4'd14;
        end else if (state == RED) begin
            if (acc[cnt]) begin
                acc <= acc ^ poly_shift;
            end
            if (!last_step) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_res   = acc[7:0];

endmodule

// File: tb/tb_gf8_poly_reduce.sv
// Bench for gf8_poly_reduce: two instances (POLY 0x11B and 0x11D) share stimulus and are
// checked through per-instance expected-result queues popped on each output handshake.
module tb_gf8_poly_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [14:0] in_prod = '0;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [7:0]  out_res_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [7:0]  out_res_b;

    gf8_poly_reduce #(.POLY(9'h11B)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_res(out_res_a), .busy(busy_a)
    );

    gf8_poly_reduce #(.POLY(9'h11D)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_res(out_res_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_xfer = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_a, exp_b;
    bit         rand_ready = 1'b0;

    // Schoolbook long division of a GF(2) polynomial by the modulus.
    function automatic logic [7:0] ref_reduce(input logic [14:0] p, input logic [8:0] poly);
        logic [14:0] r;
        r = p;
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (15'(poly) << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random consumer backpressure, only while enabled.
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: protocol invariants and scoreboard pops on each handshake.
    always @(negedge clk) begin
        if (cycle > 1) begin
            n_tests++;
            if ((in_ready_a && out_valid_a) || (in_ready_b && out_valid_b)) begin
                n_fail++;
                $display("FAIL ready_valid_overlap: in_ready=%b out_valid=%b at cycle %0d, required not both high",
                         in_ready_a, out_valid_a, cycle);
            end
            n_tests++;
            if (busy_a !== !in_ready_a || busy_b !== !in_ready_b) begin
                n_fail++;
                $display("FAIL busy_vs_ready: busy=%b in_ready=%b at cycle %0d, required busy == !in_ready",
                         busy_a, in_ready_a, cycle);
            end
            if (!rst && out_ready && out_valid_a) begin
                n_xfer++;
                n_tests++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result_a: got %h at cycle %0d, none expected", out_res_a, cycle);
                end else begin
                    exp_a = qa.pop_front();
                    if (out_res_a !== exp_a) begin
                        n_fail++;
                        $display("FAIL result_11b: got %h, required %h at cycle %0d", out_res_a, exp_a, cycle);
                    end
                end
            end
            if (!rst && out_ready && out_valid_b) begin
                n_tests++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result_b: got %h at cycle %0d, none expected", out_res_b, cycle);
                end else begin
                    exp_b = qb.pop_front();
                    if (out_res_b !== exp_b) begin
                        n_fail++;
                        $display("FAIL result_11d: got %h, required %h at cycle %0d", out_res_b, exp_b, cycle);
                    end
                end
            end
        end
    end

    // Present a product and hold it until accepted; acc_cycle is the accept edge count.
    task automatic send(input logic [14:0] p, input logic [7:0] exp_res, input bit push,
                        output int acc_cycle);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_prod  = p;
        while (!in_ready_a && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready_a) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready_a, waited);
            acc_cycle = cycle;
        end else begin
            if (push) begin
                qa.push_back(exp_res);
                qb.push_back(ref_reduce(p, 9'h11D));
            end
            tick();
            acc_cycle = cycle;
        end
    endtask

    task automatic wait_out(input int e0, output int lat);
        while (!out_valid_a && (cycle - e0) < 30) tick();
        lat = cycle - e0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while ((qa.size() != 0 || qb.size() != 0) && waited < 100) begin
            tick();
            waited++;
        end
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d/%0d results outstanding, required 0", name, qa.size(), qb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n_tests++;
        if ({in_ready_a, out_valid_a, busy_a, out_res_a} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_res=%h, required 1 0 0 00",
                     in_ready_a, out_valid_a, busy_a, out_res_a);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if ({in_ready_a, out_valid_a, busy_a, out_res_a} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
                n_fail++;
                $display("FAIL idle_hold: cycle %0d in_ready=%b out_valid=%b busy=%b out_res=%h, required 1 0 0 00",
                         i, in_ready_a, out_valid_a, busy_a, out_res_a);
            end
        end
    endtask

    task automatic test_fips();
        int e0, lat;
        out_ready = 1'b1;
        send(15'h2B79, 8'hC1, 1'b1, e0);
        in_valid = 1'b0;
        wait_out(e0, lat);
        n_tests++;
        if (lat != 7) begin
            n_fail++;
            $display("FAIL fips_latency: got %0d cycles, required 7", lat);
        end
        n_tests++;
        if (out_res_a !== 8'hC1) begin
            n_fail++;
            $display("FAIL fips_value: got %h, required c1", out_res_a);
        end
        tick();
        n_tests++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready_a, out_valid_a);
        end
        drain("fips");
    endtask

    task automatic test_back_to_back();
        logic [14:0] prods[4] = '{15'h00AE, 15'h0100, 15'h4000, 15'h0000};
        logic [7:0]  exps[4]  = '{8'hAE, 8'h1B, 8'h9A, 8'h00};
        int          acc_at[4];
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(prods[i], exps[i], 1'b1, acc_at[i]);
            if (i > 0) begin
                n_tests++;
                if (acc_at[i] - acc_at[i-1] != 9) begin
                    n_fail++;
                    $display("FAIL b2b_spacing: vector %0d got %0d cycles, required 9", i, acc_at[i] - acc_at[i-1]);
                end
            end
        end
        in_valid = 1'b0;
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int e0, lat, x0;
        out_ready = 1'b0;
        send(15'h2B79, 8'hC1, 1'b1, e0);
        in_valid = 1'b0;
        wait_out(e0, lat);
        n_tests++;
        if (lat != 7) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles, required 7", lat);
        end
        x0 = n_xfer;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_prod  = 15'($urandom_range(0, 32767));
            tick();
            n_tests++;
            if (out_valid_a !== 1'b1 || out_res_a !== 8'hC1 || in_ready_a !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b out_res=%h in_ready=%b, required 1 c1 0",
                         i, out_valid_a, out_res_a, in_ready_a);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready_a, out_valid_a);
        end
        repeat (3) tick();
        n_tests++;
        if (n_xfer - x0 != 1) begin
            n_fail++;
            $display("FAIL bp_transfers: got %0d, required 1", n_xfer - x0);
        end
        drain("bp");
    endtask

    task automatic test_reset_mid();
        int  e0, e1, lat;
        bit  seen_valid;
        out_ready = 1'b1;
        send(15'h4000, 8'h9A, 1'b0, e0);
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({in_ready_a, out_valid_a, busy_a, out_res_a} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset_state: in_ready=%b out_valid=%b busy=%b out_res=%h, required 1 0 0 00",
                     in_ready_a, out_valid_a, busy_a, out_res_a);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid_a !== 1'b0) seen_valid = 1'b1;
        end
        n_tests++;
        if (seen_valid) begin
            n_fail++;
            $display("FAIL mid_reset_no_output: out_valid rose after abort, required never");
        end
        send(15'h0100, 8'h1B, 1'b1, e1);
        in_valid = 1'b0;
        wait_out(e1, lat);
        n_tests++;
        if (lat != 7 || out_res_a !== 8'h1B) begin
            n_fail++;
            $display("FAIL mid_reset_recover: latency %0d out_res=%h, required 7 1b", lat, out_res_a);
        end
        drain("mid_reset");
    endtask

    task automatic test_random();
        int          e;
        logic [14:0] p;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            p = 15'($urandom_range(0, 32767));
            send(p, ref_reduce(p, 9'h11B), 1'b1, e);
            in_valid = 1'b0;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain("random");
    endtask

    initial begin
        test_reset();
        test_fips();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
